// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs: definitions shared by the CPU's MEM-stage peripherals.
//   UART_DATA_ADDR / UART_STAT_ADDR : UART register window. The hazard unit
//                                     also uses these for its UART no-stall check.
//   ST_*                            : bit positions inside the UART status word.
//   tx_state_e / rx_state_e         : UART serialiser / deserialiser FSM states.
//   uart_dbg_t                      : both UART FSM states bundled, so checkers
//                                     have a single signal to bind to.
//   pack_status()                   : builds the 32-bit status word.
// ---------------------------------------------------------------------------
package cpu_defs;

  localparam logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8;
  localparam logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC;

  localparam int ST_TXIDLE  = 0;
  localparam int ST_RXVALID = 1;
  localparam int ST_FERR    = 2;
  localparam int ST_OVR     = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef struct packed {
    tx_state_e tx_state;
    rx_state_e rx_state;
  } uart_dbg_t;

  function automatic logic [31:0] pack_status(input logic tx_idle,
                                              input logic rx_valid,
                                              input logic err_frame,
                                              input logic err_overrun);
    logic [31:0] s;
    s             = '0;
    s[ST_TXIDLE]  = tx_idle;
    s[ST_RXVALID] = rx_valid;
    s[ST_FERR]    = err_frame;
    s[ST_OVR]     = err_overrun;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core: 8N1 deserialiser, LSB first.
//   clk, rst  : system clock, asynchronous active-high reset
//   rxd       : raw serial input, asynchronous to clk
//   byte_o    : assembled byte; valid while done_o is high
//   done_o    : 1-clk pulse, stop bit sampled high (byte good)
//   ferr_o    : 1-clk pulse, stop bit sampled low (byte discarded)
//   state_o   : current FSM state, for debug/checkers
// A falling edge on the synchronised line starts the counter. The start bit
// is re-checked half a bit later (glitch filter); from that midpoint every
// BAUD_DIV clocks one data bit is taken, then the stop bit. The FSM goes back
// to IDLE right after the stop sample, so the next start edge is caught even
// if the sender's stop bit is slightly short.
// ---------------------------------------------------------------------------
module uart_rx_core
  import cpu_defs::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] byte_o,
  output logic       done_o,
  output logic       ferr_o,
  output rx_state_e  state_o
);

  localparam int              CNT_W     = $clog2(BAUD_DIV) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

  logic [1:0]       sync_q, sync_d;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             rxd_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  assign sync_d = {sync_q[0], rxd};
  assign rxd_s  = sync_q[1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      RX_IDLE: begin
        if (!rxd_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          bit_d = '0;
          // Line back high at mid start bit: it was a glitch.
          state_d = rxd_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Output logic: result pulses on the stop-sample cycle
  always_comb begin
    done_o = 1'b0;
    ferr_o = 1'b0;
    if (state_q == RX_STOP && cnt_q == CNT_LAST) begin
      done_o = rxd_s;
      ferr_o = !rxd_s;
    end
  end

  assign byte_o  = shift_q;
  assign state_o = state_q;

endmodule

// File: rtl/uart_mmio_responder.sv
// ---------------------------------------------------------------------------
// uart_mmio_responder: MEM-stage slave for the UART register window.
//   clk, rst           : system clock, asynchronous active-high reset
//   mem_valid          : MEM stage holds a valid instruction
//   mem_read/mem_write : load / store in MEM
//   mem_addr           : byte address (ALU result)
//   mem_wdata          : store data, low byte used
//   uart_sel           : access hits the data or status register (comb)
//   mem_rdata          : read data, zero unless a selected read (comb)
//   rxd / txd          : serial line in / out, 8N1, LSB first, idle high
// Handshake: there is none in the valid/ready sense. Every qualified access
// (uart_sel && (mem_read || mem_write)) completes in the cycle it is
// presented; read data is combinational and side effects (clear-on-read,
// TX launch) take place on the following clock edge. With mem_valid low
// nothing is selected and nothing changes.
// ---------------------------------------------------------------------------
module uart_mmio_responder
  import cpu_defs::*;
#(
  parameter int          CLK_FREQ  = 50_000_000,
  parameter int          BAUD      = 115200,
  parameter logic [31:0] DATA_ADDR = UART_DATA_ADDR,
  parameter logic [31:0] STAT_ADDR = UART_STAT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        uart_sel,
  output logic [31:0] mem_rdata,
  input  logic        rxd,
  output logic        txd
);

  localparam int               BAUD_DIV = CLK_FREQ / BAUD;
  localparam int               CNT_W    = $clog2(BAUD_DIV) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  // ---------------- register decode ----------------
  logic hit_data, hit_stat, access;
  logic rd_data, rd_stat, wr_data;

  assign hit_data = (mem_addr == DATA_ADDR);
  assign hit_stat = (mem_addr == STAT_ADDR);
  assign uart_sel = mem_valid && (hit_data || hit_stat);
  assign access   = uart_sel && (mem_read || mem_write);
  assign rd_data  = access && mem_read  && hit_data;
  assign rd_stat  = access && mem_read  && hit_stat;
  assign wr_data  = access && mem_write && hit_data;

  // ---------------- receiver ----------------
  logic [7:0] rx_byte;
  logic       rx_done, rx_ferr;
  rx_state_e  rx_state;

  uart_rx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rxd     (rxd),
    .byte_o  (rx_byte),
    .done_o  (rx_done),
    .ferr_o  (rx_ferr),
    .state_o (rx_state)
  );

  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;
  logic       err_frame_q, err_frame_d;
  logic       err_overrun_q, err_overrun_d;

  // A completing byte beats a same-cycle DATA read: the read sees the old
  // byte and the new one stays pending, so that case is not an overrun.
  // Error sets likewise beat a same-cycle STAT read clear.
  always_comb begin
    rx_byte_d     = rx_done ? rx_byte : rx_byte_q;
    rx_valid_d    = rx_valid_q;
    err_frame_d   = rd_stat ? 1'b0 : err_frame_q;
    err_overrun_d = rd_stat ? 1'b0 : err_overrun_q;
    if (rd_data) rx_valid_d = 1'b0;
    if (rx_done) rx_valid_d = 1'b1;
    if (rx_ferr) err_frame_d = 1'b1;
    if (rx_done && rx_valid_q && !rd_data) err_overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_byte_q     <= '0;
      rx_valid_q    <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      rx_byte_q     <= rx_byte_d;
      rx_valid_q    <= rx_valid_d;
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             txd_q, txd_d;
  logic             tx_idle;

  assign tx_idle = (tx_state_q == TX_IDLE);

  // State register; txd is a flop so the line never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // Next-state logic. Writes while busy are dropped; software polls tx_idle.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (wr_data) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_shift_d = mem_wdata[7:0];
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Output logic: line level follows the *next* state so the start bit
  // appears on the edge that accepts the write.
  always_comb begin
    txd_d = 1'b1;
    unique case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  assign txd = txd_q;

  // ---------------- read mux ----------------
  always_comb begin
    mem_rdata = '0;
    if (uart_sel && mem_read) begin
      mem_rdata = hit_data ? {24'b0, rx_byte_q}
                           : pack_status(tx_idle, rx_valid_q, err_frame_q, err_overrun_q);
    end
  end

  // Both FSM states in one bind point for checkers.
  uart_dbg_t dbg;
  assign dbg.tx_state = tx_state_q;
  assign dbg.rx_state = rx_state;

  // Upper store-data bits are don't-care; dbg is observed only hierarchically.
  logic unused_ok;
  assign unused_ok = ^{mem_wdata[31:8], dbg};

endmodule
